risc16_ctrl: RTL and testbench

Multi-cycle control FSM for the RISC-16 core. It fetches instructions over an instruction-memory request/acknowledge handshake and holds the instruction register. It sequences decode, execute, data-memory access and write-back. It drives the program-counter update strobes (pc_we, branch_en, jalr_en) and the register-file write enable, so the PC advances exactly once per retired instruction.

---
 rtl/risc16_ctrl.sv | 154 +++++++++++++++
 tb/tb_risc16_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/risc16_ctrl.sv
// Multi-cycle control FSM for the RISC-16 core: fetch handshake, instruction register,
// PC/regfile strobes, retired-instruction counter and ack-timeout bus error.
module risc16_ctrl #(
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [15:0]      imem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  input  logic             eq,
  output logic [15:0]      ir,
  output logic             pc_we,
  output logic             branch_en,
  output logic             jalr_en,
  output logic             reg_we,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W  = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int TO_LAST = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;

  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t              r_state, w_next;
  logic [15:0]         r_ir;
  logic [CNT_W-1:0]    r_retired;
  logic                r_halted, r_bus_err;
  logic [WAIT_W-1:0]   r_wait;

  logic                w_load, w_retire, w_timeout, w_waiting, w_wait_hit;
  logic [2:0]          w_op;
  logic                w_rA_nz, w_is_halt;

  assign w_op       = r_ir[15:13];
  assign w_rA_nz    = (r_ir[12:10] != 3'd0);
  assign w_is_halt  = (w_op == OP_JALR) && (r_ir[6:0] != 7'd0);
  assign w_wait_hit = (ACK_TIMEOUT != 0) && (r_wait == WAIT_W'(TO_LAST));

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_retire  = 1'b0;
    w_timeout = 1'b0;
    w_waiting = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_we     = 1'b0;
    branch_en = 1'b0;
    jalr_en   = 1'b0;
    reg_we    = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        // Gated so the request first appears in the cycle after reset release.
        imem_req = reset_n;
        if (imem_ack) begin
          w_load = 1'b1;
          w_next = S_DECODE;
        end else begin
          w_waiting = 1'b1;
          if (w_wait_hit) begin
            w_timeout = 1'b1;
            w_next    = S_HALT;
          end
        end
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (w_op == OP_SW || w_op == OP_LW) begin
          w_next = S_MEM;
        end else if (w_op == OP_BEQ) begin
          pc_we     = 1'b1;
          branch_en = eq;
          w_retire  = 1'b1;
          w_next    = S_FETCH;
        end else if (w_is_halt) begin
          w_next = S_HALT;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (w_op == OP_SW);
        if (dmem_ack) begin
          if (w_op == OP_SW) begin
            pc_we    = 1'b1;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else begin
          w_waiting = 1'b1;
          if (w_wait_hit) begin
            w_timeout = 1'b1;
            w_next    = S_HALT;
          end
        end
      end
      S_WB: begin
        reg_we   = w_rA_nz;
        pc_we    = 1'b1;
        jalr_en  = (w_op == OP_JALR);
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_ir      <= '0;
      r_retired <= '0;
      r_halted  <= 1'b0;
      r_bus_err <= 1'b0;
      r_wait    <= '0;
    end else begin
      r_state <= w_next;
      if (w_load)              r_ir      <= imem_rdata;
      if (w_retire)            r_retired <= r_retired + CNT_W'(1);
      if (w_next == S_HALT)    r_halted  <= 1'b1;
      if (w_timeout)           r_bus_err <= 1'b1;
      // Counter restarts on every entry to a waiting state.
      if (w_next != r_state && (w_next == S_FETCH || w_next == S_MEM))
        r_wait <= '0;
      else if (w_waiting)
        r_wait <= r_wait + WAIT_W'(1);
    end
  end

  assign ir      = r_ir;
  assign retired = r_retired;
  assign halted  = r_halted;
  assign bus_err = r_bus_err;

endmodule

// File: tb/tb_risc16_ctrl.sv
// Self-checking bench for risc16_ctrl: table of instructions expanded into per-cycle
// expected outputs on a scoreboard, plus timeout, halt and mid-access reset sequences.
module tb_risc16_ctrl;

  localparam int TCW = 4;

  logic           clk, reset_n;
  logic           imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, eq;
  logic [15:0]    imem_rdata, ir;
  logic           pc_we, branch_en, jalr_en, reg_we, halted, bus_err;
  logic [TCW-1:0] retired;

  risc16_ctrl #(.ACK_TIMEOUT(4), .CNT_W(TCW)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .eq(eq),
    .ir(ir), .pc_we(pc_we), .branch_en(branch_en), .jalr_en(jalr_en),
    .reg_we(reg_we), .halted(halted), .bus_err(bus_err), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag bits: imem_req,dmem_req,dmem_we,pc_we,branch_en,jalr_en,reg_we,halted,bus_err
  localparam logic [8:0] IREQ = 9'h100, DREQ = 9'h080, DWE = 9'h040, PCW = 9'h020,
                         BR = 9'h010, JR = 9'h008, RW = 9'h004, HLT = 9'h002, BERR = 9'h001;

  typedef struct packed {
    logic [8:0]     f;
    logic [15:0]    ir;
    logic [TCW-1:0] ret;
  } exp_t;

  typedef enum int { K_ALU, K_BEQ, K_LW, K_SW, K_JALR, K_HALT } kind_t;

  typedef struct {
    logic [15:0] instr;
    logic        eq;
    int          iw;
    int          dw;
    kind_t       kind;
    logic        rw;
    logic        br;
  } vec_t;

  exp_t           sb[$];
  string          nm_q[$];
  int             checks = 0, failures = 0;
  logic [15:0]    m_ir;
  logic [TCW-1:0] m_ret;
  logic           rn_drv;

  function automatic exp_t cur();
    exp_t a;
    a.f   = {imem_req, dmem_req, dmem_we, pc_we, branch_en, jalr_en, reg_we, halted, bus_err};
    a.ir  = ir;
    a.ret = retired;
    return a;
  endfunction

  function automatic exp_t mkx(input logic [8:0] f);
    exp_t x;
    x.f = f; x.ir = m_ir; x.ret = m_ret;
    return x;
  endfunction

  task automatic chk(input string nm, input exp_t a, input exp_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got flags=%b ir=%h ret=%0d, want flags=%b ir=%h ret=%0d",
               nm, a.f, a.ir, a.ret, e.f, e.ir, e.ret);
    end
  endtask

  always begin
    @(negedge clk);
    #2;
    if (sb.size() > 0) chk(nm_q.pop_front(), cur(), sb.pop_front());
  end

  task automatic cyc(input string nm, input logic ia, input logic [15:0] rd,
                     input logic da, input logic e, input exp_t x);
    @(negedge clk);
    reset_n = rn_drv; imem_ack = ia; imem_rdata = rd; dmem_ack = da; eq = e;
    sb.push_back(x);
    nm_q.push_back(nm);
  endtask

  task automatic run_instr(input vec_t v);
    logic [8:0] f;
    for (int k = 0; k <= v.iw; k++)
      cyc("fetch", k == v.iw, (k == v.iw) ? v.instr : 16'($urandom), 1'b0,
          1'($urandom), mkx(IREQ));
    m_ir = v.instr;
    cyc("decode", 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), mkx(9'h0));
    f = (v.kind == K_BEQ) ? (PCW | (v.br ? BR : 9'h0)) : 9'h0;
    cyc("exec", 1'($urandom), 16'($urandom), 1'($urandom), v.eq, mkx(f));
    if (v.kind == K_BEQ) begin m_ret++; return; end
    if (v.kind == K_HALT) return;
    if (v.kind == K_LW || v.kind == K_SW) begin
      for (int k = 0; k <= v.dw; k++) begin
        f = DREQ | ((v.kind == K_SW) ? DWE : 9'h0) |
            ((v.kind == K_SW && k == v.dw) ? PCW : 9'h0);
        cyc("mem", 1'($urandom), 16'($urandom), k == v.dw, 1'($urandom), mkx(f));
      end
      if (v.kind == K_SW) begin m_ret++; return; end
    end
    f = PCW | ((v.kind == K_JALR) ? JR : 9'h0) | (v.rw ? RW : 9'h0);
    cyc("wb", 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), mkx(f));
    m_ret++;
  endtask

  task automatic do_reset(input string nm);
    rn_drv = 1'b0; m_ir = '0; m_ret = '0;
    cyc(nm, 1'b0, 16'h0, 1'b0, 1'b0, mkx(9'h0));
    cyc(nm, 1'b1, 16'hFFFF, 1'b1, 1'b1, mkx(9'h0));
    rn_drv = 1'b1;
  endtask

  vec_t tbl[13];
  vec_t v;

  initial begin
    tbl[0]  = '{16'h2481, 1'b0, 0, 0, K_ALU,  1'b1, 1'b0};  // ADDI r1
    tbl[1]  = '{16'hC005, 1'b1, 0, 0, K_BEQ,  1'b0, 1'b1};  // BEQ taken
    tbl[2]  = '{16'hC005, 1'b0, 1, 0, K_BEQ,  1'b0, 1'b0};  // BEQ not taken
    tbl[3]  = '{16'hA481, 1'b0, 0, 3, K_LW,   1'b1, 1'b0};  // LW, ack on 4th mem cycle
    tbl[4]  = '{16'h8481, 1'b0, 0, 1, K_SW,   1'b0, 1'b0};
    tbl[5]  = '{16'hE400, 1'b0, 0, 0, K_JALR, 1'b1, 1'b0};
    tbl[6]  = '{16'h0002, 1'b1, 0, 0, K_ALU,  1'b0, 1'b0};  // ADD to r0
    tbl[7]  = '{16'h4C05, 1'b0, 2, 0, K_ALU,  1'b1, 1'b0};  // NAND r3
    tbl[8]  = '{16'h7FFF, 1'b1, 1, 0, K_ALU,  1'b1, 1'b0};  // LUI r7
    tbl[9]  = '{16'hA07F, 1'b0, 0, 0, K_LW,   1'b0, 1'b0};  // LW to r0
    tbl[10] = '{16'hE000, 1'b1, 0, 0, K_JALR, 1'b0, 1'b0};  // JALR r0
    tbl[11] = '{16'hDC7F, 1'b1, 3, 0, K_BEQ,  1'b0, 1'b1};  // fetch ack on 4th cycle
    tbl[12] = '{16'h9C00, 1'b0, 0, 0, K_SW,   1'b0, 1'b0};

    reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; eq = 1'b0;
    do_reset("reset");

    // Two passes retire 26 instructions, wrapping the 4-bit counter.
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 13; i++) run_instr(tbl[i]);

    v = '{16'hE001, 1'b1, 0, 0, K_HALT, 1'b0, 1'b0};
    run_instr(v);
    for (int k = 0; k < 20; k++)
      cyc("halted", 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), mkx(HLT));

    // Fetch timeout: no ack for 4 cycles.
    do_reset("reset2");
    for (int k = 0; k < 4; k++) cyc("to_wait", 1'b0, 16'h2481, 1'b0, 1'b0, mkx(IREQ));
    for (int k = 0; k < 3; k++)
      cyc("to_halt", 1'($urandom), 16'($urandom), 1'($urandom), 1'b0, mkx(HLT | BERR));

    // Ack on the limit cycle wins.
    do_reset("reset3");
    v = '{16'h2481, 1'b0, 3, 0, K_ALU, 1'b1, 1'b0};
    run_instr(v);
    run_instr(tbl[3]);

    // Reset in the middle of a data access.
    cyc("fetch_lw", 1'b1, 16'hA481, 1'b0, 1'b0, mkx(IREQ));
    m_ir = 16'hA481;
    cyc("decode_lw", 1'b0, 16'h0, 1'b0, 1'b0, mkx(9'h0));
    cyc("exec_lw", 1'b0, 16'h0, 1'b0, 1'b0, mkx(9'h0));
    cyc("mem_lw", 1'b0, 16'h0, 1'b0, 1'b0, mkx(DREQ));
    #3;
    reset_n = 1'b0; rn_drv = 1'b0; m_ir = '0; m_ret = '0;
    #1;
    chk("midmem_reset", cur(), mkx(9'h0));
    cyc("in_reset", 1'b0, 16'h0, 1'b1, 1'b0, mkx(9'h0));
    rn_drv = 1'b1;
    cyc("post_reset", 1'b0, 16'h0, 1'b1, 1'b0, mkx(IREQ));

    @(negedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
